// File: rtl/board_ctrl.sv
// board_ctrl
// Board-support glue between the clock generator and the game core.
//   - Qualifies the PLL/MMCM lock into a stretched, synchronously released
//     active-low core reset (HOLD -> COUNT -> RUN sequencer).
//   - Synchronises and debounces NUM_BTN raw buttons into level, press and
//     release outputs.
//   - Generates a heartbeat toggle and a coincident tick pulse for LEDs.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset, clears all state
//   i_locked       clock-generator lock, asynchronous level
//   i_btn          raw asynchronous active-high buttons [NUM_BTN]
//   o_rst_n        registered active-low core reset
//   o_btn_level    debounced button level [NUM_BTN]
//   o_btn_press    one-cycle pulse on each accepted 0->1 change [NUM_BTN]
//   o_btn_release  one-cycle pulse on each accepted 1->0 change [NUM_BTN]
//   o_heartbeat    toggles once every HEARTBEAT_DIV cycles while running
//   o_tick         one-cycle pulse coincident with each heartbeat toggle
module board_ctrl #(
  parameter int POR_CYCLES      = 256,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HEARTBEAT_DIV   = 25174014
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_locked,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic               o_rst_n,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release,
  output logic               o_heartbeat,
  output logic               o_tick
);

  // Counter widths never drop below one bit, so a parameter of 1 still works.
  localparam int PW = (POR_CYCLES      > 1) ? $clog2(POR_CYCLES)      : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HEARTBEAT_DIV   > 1) ? $clog2(HEARTBEAT_DIV)   : 1;

  localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST  = HW'(HEARTBEAT_DIV - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                     state;
  logic [PW-1:0]              cnt;
  logic                       lock_meta;
  logic                       locked_s;
  logic                       run;

  logic [NUM_BTN-1:0]         btn_meta;
  logic [NUM_BTN-1:0]         btn_sync;
  logic [NUM_BTN-1:0][DW-1:0] dcnt;

  logic [HW-1:0]              hcnt;

  assign run = (state == RUN);

  // Two-flop synchroniser for the asynchronous lock level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= i_locked;
      locked_s  <= lock_meta;
    end
  end

  // Reset sequencer. A lock loss from any state returns to HOLD, so a drop
  // part-way through COUNT restarts the whole stretch on the next lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD;
      cnt     <= '0;
      o_rst_n <= 1'b0;
    end else if (!locked_s) begin
      state   <= HOLD;
      cnt     <= '0;
      o_rst_n <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          state <= COUNT;
          cnt   <= '0;
        end
        COUNT: begin
          if (cnt == POR_LAST) begin
            state   <= RUN;
            o_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        RUN: begin
          state   <= RUN;
          o_rst_n <= 1'b1;
        end
        default: begin
          state   <= HOLD;
          cnt     <= '0;
          o_rst_n <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel debouncer. The synchroniser flops are also held clear
  // outside RUN so every run starts from a known released state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta      <= '0;
      btn_sync      <= '0;
      dcnt          <= '0;
      o_btn_level   <= '0;
      o_btn_press   <= '0;
      o_btn_release <= '0;
    end else if (!run) begin
      btn_meta      <= '0;
      btn_sync      <= '0;
      dcnt          <= '0;
      o_btn_level   <= '0;
      o_btn_press   <= '0;
      o_btn_release <= '0;
    end else begin
      btn_meta <= i_btn;
      btn_sync <= btn_meta;
      for (int i = 0; i < NUM_BTN; i++) begin
        o_btn_press[i]   <= 1'b0;
        o_btn_release[i] <= 1'b0;
        if (btn_sync[i] == o_btn_level[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          o_btn_level[i]   <= btn_sync[i];
          o_btn_press[i]   <= btn_sync[i];
          o_btn_release[i] <= ~btn_sync[i];
          dcnt[i]          <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // Heartbeat divider; the tick is registered alongside the toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      o_heartbeat <= 1'b0;
      o_tick      <= 1'b0;
    end else if (!run) begin
      hcnt        <= '0;
      o_heartbeat <= 1'b0;
      o_tick      <= 1'b0;
    end else if (hcnt == HB_LAST) begin
      hcnt        <= '0;
      o_heartbeat <= ~o_heartbeat;
      o_tick      <= 1'b1;
    end else begin
      hcnt   <= hcnt + HW'(1);
      o_tick <= 1'b0;
    end
  end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Parametrised board-support controller between the clock-generation primitive and the game core on the FPGA build. It qualifies a PLL/MMCM lock signal into a stretched, synchronously released core reset. It synchronises and debounces NUM_BTN push-buttons into level, press and release outputs. It also generates a programmable heartbeat toggle and a tick pulse for status LEDs.

## Interface

Parameters:
- POR_CYCLES, default 256: reset stretch length after lock; minimum 1.
- NUM_BTN, default 4: number of button channels; minimum 1.
- DEBOUNCE_CYCLES, default 65536: number of stable synchronised cycles required to accept a button change; minimum 1.
- HEARTBEAT_DIV, default 25174014: heartbeat half-period in clock cycles; minimum 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset, clears all state.
- i_locked, input, 1: clock-generator lock; asynchronous to the block's logic; used as a level.
- i_btn, input, NUM_BTN: raw, asynchronous, active-high buttons.
- o_rst_n, output, 1: registered active-low core reset.
- o_btn_level, output, NUM_BTN: debounced button level.
- o_btn_press, output, NUM_BTN: one-cycle pulse on each accepted 0->1 change.
- o_btn_release, output, NUM_BTN: one-cycle pulse on each accepted 1->0 change.
- o_heartbeat, output, 1: toggles once per HEARTBEAT_DIV cycles.
- o_tick, output, 1: one-cycle pulse coincident with each heartbeat toggle.

## Operation

- **Reset values.** While rst_n is low, every output is 0 and all counters and synchroniser flops are 0. The sequencer state is HOLD.
- **Sequencer FSM.** States are HOLD, COUNT and RUN. i_locked passes through a 2-flop synchroniser (locked_s) before use.
  - HOLD: when locked_s = 1, go to COUNT with cnt = 0.
  - COUNT: when cnt == POR_CYCLES-1, go to RUN and set o_rst_n to 1. Otherwise cnt increments.
  - Any state: when locked_s = 0, go to HOLD next edge; cnt and o_rst_n are cleared. A lock drop mid-COUNT restarts the full stretch.
- **Run qualification.** The debouncers and heartbeat are synchronously held at their reset values while the state is not RUN.
- **Debouncer.** Each channel has its own 2-flop synchroniser (sync), counter dcnt and level register.
  - sync == level: dcnt is cleared.
  - sync != level and dcnt == DEBOUNCE_CYCLES-1: level takes sync, dcnt is cleared, and press or release pulses for one cycle.
  - sync != level otherwise: dcnt increments.
  - Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- **Heartbeat.** Counter hcnt runs 0 to HEARTBEAT_DIV-1.
  - At HEARTBEAT_DIV-1: hcnt wraps to 0, o_heartbeat toggles and o_tick is 1.
  - Otherwise: o_tick is 0.
- **Widths.** Counters are $clog2(param) bits, with a minimum of 1 bit. No counter may overflow past its terminal value.

## Timing

- **Reset release.** o_rst_n rises exactly POR_CYCLES+3 rising edges after i_locked goes high, provided i_locked stays high throughout. This is 2 edges of lock synchronisation plus POR_CYCLES+1 edges in HOLD and COUNT.
- **Reset assertion.** o_rst_n falls 3 edges after i_locked goes low. rst_n assertion clears o_rst_n asynchronously, immediately.
- **Button latency.** A raw change that is stable from edge 1 updates o_btn_level and asserts the press or release pulse at edge DEBOUNCE_CYCLES+2. The pulse lasts exactly 1 cycle.
- **Glitch rejection.** A change that returns to its prior value before it has been seen on sync for DEBOUNCE_CYCLES consecutive edges produces no level change and no pulse.
- **Heartbeat start.** The first o_tick and o_heartbeat toggle occur HEARTBEAT_DIV edges after entering RUN. Thereafter they repeat every HEARTBEAT_DIV edges.
- **Leaving RUN.** Any exit from RUN clears o_heartbeat, o_tick, all levels and all pulses on the next edge.

## Test plan

Benches use POR_CYCLES=4, NUM_BTN=2, DEBOUNCE_CYCLES=8 and HEARTBEAT_DIV=5.

- **Power-up sequence.** Hold rst_n low, release it, then raise i_locked at edge 0. o_rst_n must be 0 through edge 6 and 1 from edge 7 onward. All other outputs must be 0 until RUN.
- **Lock drop.** Drop i_locked 2 edges after it rises, then raise it again. o_rst_n must stay low, and the full 7-edge delay must restart from the second rise.
- **Clean press and release.** In RUN, raise i_btn[0] at edge 1. o_btn_level[0] and o_btn_press[0] must become 1 at edge 10, and o_btn_press[0] must return to 0 at edge 11. Lower the button and check for a single o_btn_release[0] pulse 10 edges later.
- **Glitch rejection.** Apply a 5-cycle high glitch on i_btn[1]. There must be no level change and no pulses. Pulse both buttons together and check for coincident press pulses on both channels.
- **Heartbeat.** o_tick must pulse at 5, 10 and 15 edges after entering RUN, with o_heartbeat reading 1, 0, 1 after those pulses. Then drop i_locked and check that o_heartbeat and o_tick clear on the edge after the sequencer leaves RUN.
- **Asynchronous reset mid-count.** Assert rst_n mid-debounce and mid-heartbeat. All outputs must go to 0 immediately, with no clock edge required.
